sp_mem_responder: RTL and testbench
===================================

// Module: sp_mem_responder
// PURPOSE
//  Synthesizable single-port memory target answering the memory-driver BFM's wr_en/rd_en/address/wr_data bus.
//  Stores writes, returns read data after a fixed pipelined latency with a valid strobe.
//  Classifies traffic into sequential bursts and reports each burst's length and type on completion.
//  Sits at the memory end of the single-port bench; also usable as the RTL memory model.
// PARAMETERS
//  DATA_WIDTH    8   data bus width, bits
//  ADDR_WIDTH    8   address width; DEPTH = 2**ADDR_WIDTH words
//  READ_LATENCY  1   cycles from rd_en sampled to o_rd_valid; legal 1..4
//  CNT_WIDTH     16  width of access counters and burst length
// PORTS
//  i_clk           in   1           clock, all logic on rising edge
//  i_rst_n         in   1           asynchronous active-low reset
//  i_wr_en         in   1           write request, sampled at posedge
//  i_rd_en         in   1           read request, sampled at posedge
//  i_address       in   ADDR_WIDTH  word address
//  i_wr_data       in   DATA_WIDTH  write data
//  o_rd_data       out  DATA_WIDTH  read data, held until next valid
//  o_rd_valid      out  1           1-cycle pulse, o_rd_data valid
//  o_collision     out  1           1-cycle pulse: wr_en & rd_en same cycle
//  o_burst_done    out  1           1-cycle pulse: a burst ended
//  o_burst_is_wr   out  1           type of reported burst (1 = write)
//  o_burst_len     out  CNT_WIDTH   length of reported burst, beats
//  o_wr_count      out  CNT_WIDTH   total accepted writes, wraps
//  o_rd_count      out  CNT_WIDTH   total accepted reads, wraps
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, read pipe cleared. Memory array NOT reset; contents undefined until written.
//  Reset mid-operation: in-flight reads dropped (no o_rd_valid); open burst discarded, not reported.
//  Write: wr_en=1 at posedge -> mem[address] <= wr_data that edge; o_wr_count++.
//  Read: rd_en=1 (wr_en=0) at posedge -> array read at that edge.
//   - o_rd_data/o_rd_valid appear READ_LATENCY cycles later. Back-to-back reads give back-to-back valids.
//   - Data is the array value at the sampling edge; a later write to the same address does not alter an in-flight read.
//   - o_rd_count++ at the sampling edge.
//  Collision (wr_en & rd_en): write performed, read suppressed (no valid, no rd_count), o_collision pulses next cycle.
//  Burst FSM states IDLE, WR_BURST, RD_BURST; len register counts current burst beats.
//   - IDLE: wr -> WR_BURST, len=1; rd -> RD_BURST, len=1; none -> stay.
//   - In-burst, same op with address == last_addr+1 mod DEPTH (wrap counts as sequential): stay, len++ saturating at all-ones.
//   - Same op, non-sequential address: report current burst, start new one with len=1, same state.
//   - Opposite op: report, move to other burst state, len=1.
//   - No request: report, go IDLE.
//   - A collision beat counts as a write.
//  Report = o_burst_done=1, o_burst_is_wr, o_burst_len registered the cycle after the ending edge.
//   o_burst_is_wr/o_burst_len hold until the next report.
//  Counters wrap modulo 2**CNT_WIDTH; address arithmetic is modulo DEPTH.
// STRUCTURE
//  Shared package sp_mem_pkg: burst_state_t enum (IDLE, WR_BURST, RD_BURST), READ_LATENCY_MAX=4 constant.
//  One sub-module: sp_mem_rd_pipe (parameterized valid/data shift pipe, depth READ_LATENCY-1 after array read stage).
//  Array, FSM, counters in top.
//  Elaboration error if READ_LATENCY outside 1..4.
// TESTING
//  1 Reset: assert i_rst_n=0 mid-traffic -> all outputs 0 immediately; no later rd_valid from pre-reset reads.
//  2 Write 4 beats addr 0x10..0x13 data 0x21..0x24, then read 0x10..0x13 -> rd_valid exactly READ_LATENCY cycles after each
//    rd_en with 0x21..0x24; bursts reported (wr,4) then (rd,4); wr_count=4, rd_count=4.
//  3 Wrap: write 0xFE,0xFF,0x00 then idle -> single report (wr,3).
//  4 Collision: wr_en=rd_en=1 addr 0x05 data 0xAA -> o_collision pulse, no rd_valid, rd_count unchanged;
//    subsequent read 0x05 returns 0xAA.
//  5 Read-then-write hazard, READ_LATENCY=3: mem[0x20]=0x11; read 0x20 then write 0x20=0x99 next cycle -> returned data 0x11.
//  6 Non-sequential: writes to 0x30,0x31,0x40 -> report (wr,2) when 0x40 sampled, then (wr,1) on idle.

Source files
------------

// File: rtl/sp_mem_pkg.sv
// Shared types and limits for the single-port memory responder.
// Burst tracker state encoding and the supported read-latency range.
package sp_mem_pkg;

    localparam int READ_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } burst_state_t;

endpackage

// File: rtl/sp_mem_rd_pipe.sv
// Valid/data delay line that follows the array read stage.
// Each stage captures data only when its incoming valid is set, so the last stage holds its value between valids.
module sp_mem_rd_pipe #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stage_valid,
    input  logic [WIDTH-1:0] stage_data,
    output logic             pipe_valid,
    output logic [WIDTH-1:0] pipe_data
);

    if (DEPTH == 0) begin : g_bypass
        assign pipe_valid = stage_valid;
        assign pipe_data  = stage_data;
    end else begin : g_pipe
        logic [DEPTH-1:0] valid_sr;
        logic [WIDTH-1:0] data_sr [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_sr <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    data_sr[i] <= '0;
                end
            end else begin
                valid_sr[0] <= stage_valid;
                if (stage_valid) begin
                    data_sr[0] <= stage_data;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    valid_sr[i] <= valid_sr[i-1];
                    if (valid_sr[i-1]) begin
                        data_sr[i] <= data_sr[i-1];
                    end
                end
            end
        end

        assign pipe_valid = valid_sr[DEPTH-1];
        assign pipe_data  = data_sr[DEPTH-1];
    end

endmodule

// File: rtl/sp_mem_responder.sv
// Single-port memory target: stores writes, returns reads after READ_LATENCY cycles,
// counts accesses and reports each sequential burst (type, length) when it ends.
module sp_mem_responder
    import sp_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_collision,
    output logic                  o_burst_done,
    output logic                  o_burst_is_wr,
    output logic [CNT_WIDTH-1:0]  o_burst_len,
    output logic [CNT_WIDTH-1:0]  o_wr_count,
    output logic [CNT_WIDTH-1:0]  o_rd_count,
    output burst_state_t          o_burst_state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (READ_LATENCY < 1 || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
        $error("sp_mem_responder: READ_LATENCY must be in 1..%0d", READ_LATENCY_MAX);
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A collision is treated as a write; the read half is dropped.
    logic wr_beat;
    logic rd_beat;
    assign wr_beat = i_wr_en;
    assign rd_beat = i_rd_en & ~i_wr_en;

    // Array and read stage

    always_ff @(posedge i_clk) begin
        if (wr_beat) begin
            mem[i_address] <= i_wr_data;
        end
    end

    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            stage_valid <= rd_beat;
            if (rd_beat) begin
                stage_data <= mem[i_address];
            end
        end
    end

    sp_mem_rd_pipe #(
        .DEPTH (READ_LATENCY - 1),
        .WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .pipe_valid  (o_rd_valid),
        .pipe_data   (o_rd_data)
    );

    // Counters and collision flag

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_count  <= '0;
            o_rd_count  <= '0;
            o_collision <= 1'b0;
        end else begin
            if (wr_beat) begin
                o_wr_count <= o_wr_count + CNT_WIDTH'(1);
            end
            if (rd_beat) begin
                o_rd_count <= o_rd_count + CNT_WIDTH'(1);
            end
            o_collision <= i_wr_en & i_rd_en;
        end
    end

    // Burst tracker

    burst_state_t          state;
    burst_state_t          state_nxt;
    logic [CNT_WIDTH-1:0]  len;
    logic [CNT_WIDTH-1:0]  len_nxt;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  seq_addr;
    logic [CNT_WIDTH-1:0]  len_inc;

    assign seq_addr = (i_address == ADDR_WIDTH'(last_addr + ADDR_WIDTH'(1)));
    assign len_inc  = (len == '1) ? len : len + CNT_WIDTH'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            len       <= '0;
            last_addr <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
            if (wr_beat || rd_beat) begin
                last_addr <= i_address;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        if (wr_beat) begin
            state_nxt = WR_BURST;
            len_nxt   = (state == WR_BURST && seq_addr) ? len_inc : CNT_WIDTH'(1);
        end else if (rd_beat) begin
            state_nxt = RD_BURST;
            len_nxt   = (state == RD_BURST && seq_addr) ? len_inc : CNT_WIDTH'(1);
        end else begin
            state_nxt = IDLE;
            len_nxt   = '0;
        end
    end

    // An open burst ends unless this beat is the same op at the next address.
    logic report;
    logic report_is_wr;

    always_comb begin
        report       = 1'b0;
        report_is_wr = 1'b0;
        case (state)
            WR_BURST: begin
                report       = !(wr_beat && seq_addr);
                report_is_wr = 1'b1;
            end
            RD_BURST: begin
                report       = !(rd_beat && seq_addr);
                report_is_wr = 1'b0;
            end
            default: begin
                report       = 1'b0;
                report_is_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_burst_done  <= 1'b0;
            o_burst_is_wr <= 1'b0;
            o_burst_len   <= '0;
        end else begin
            o_burst_done <= report;
            if (report) begin
                o_burst_is_wr <= report_is_wr;
                o_burst_len   <= len;
            end
        end
    end

    assign o_burst_state = state;

endmodule

// File: tb/tb_sp_mem_responder.sv
// Self-checking bench for sp_mem_responder: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_sp_mem_responder;
    import sp_mem_pkg::*;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  address = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        collision;
    logic        burst_done;
    logic        burst_is_wr;
    logic [15:0] burst_len;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    burst_state_t burst_state;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    sp_mem_responder #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (8),
        .READ_LATENCY (RL),
        .CNT_WIDTH    (16)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wr_en       (wr_en),
        .i_rd_en       (rd_en),
        .i_address     (address),
        .i_wr_data     (wr_data),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_collision   (collision),
        .o_burst_done  (burst_done),
        .o_burst_is_wr (burst_is_wr),
        .o_burst_len   (burst_len),
        .o_wr_count    (wr_count),
        .o_rd_count    (rd_count),
        .o_burst_state (burst_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) begin
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
            end
        end
    endtask

    // Reference model: memory image, reads in flight, open burst.
    logic [7:0]  m_mem [256];
    bit          m_known [256];
    int          due_q [$];
    logic [7:0]  exp_q [$];
    bit          known_q [$];
    int          cyc = 0;
    bit          m_valid = 0;
    logic [7:0]  m_data = '0;
    bit          m_data_known = 1;
    bit          m_coll = 0;
    logic [15:0] m_wr_cnt = '0;
    logic [15:0] m_rd_cnt = '0;
    bit          m_done = 0;
    bit          m_is_wr = 0;
    logic [15:0] m_len = '0;
    bit          open = 0;
    int          open_type = 0;
    logic [7:0]  open_last = '0;
    logic [15:0] open_len = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            due_q.delete();
            exp_q.delete();
            known_q.delete();
            m_valid = 0; m_data = '0; m_data_known = 1; m_coll = 0;
            m_wr_cnt = '0; m_rd_cnt = '0;
            m_done = 0; m_is_wr = 0; m_len = '0; open = 0;
        end else begin
            int op;
            cyc++;
            op = wr_en ? 1 : (rd_en ? 2 : 0);
            if (op == 2) begin
                due_q.push_back(cyc + RL - 1);
                exp_q.push_back(m_mem[address]);
                known_q.push_back(m_known[address]);
                m_rd_cnt = m_rd_cnt + 16'd1;
            end
            if (op == 1) begin
                m_mem[address] = wr_data;
                m_known[address] = 1;
                m_wr_cnt = m_wr_cnt + 16'd1;
            end
            m_valid = 0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                m_data = exp_q.pop_front();
                m_data_known = known_q.pop_front();
                m_valid = 1;
            end
            m_coll = wr_en & rd_en;
            m_done = 0;
            if (open) begin
                if (op == open_type && address == 8'(open_last + 8'd1)) begin
                    if (open_len != 16'hFFFF) open_len = open_len + 16'd1;
                    open_last = address;
                end else begin
                    m_done = 1;
                    m_is_wr = (open_type == 1);
                    m_len = open_len;
                    open = 0;
                end
            end
            if (!open && op != 0) begin
                open = 1; open_type = op; open_len = 16'd1; open_last = address;
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (check_en) begin
            check("rd_valid", 32'(rd_valid), 32'(m_valid));
            if (m_data_known) check("rd_data", 32'(rd_data), 32'(m_data));
            check("collision", 32'(collision), 32'(m_coll));
            check("burst_done", 32'(burst_done), 32'(m_done));
            check("burst_is_wr", 32'(burst_is_wr), 32'(m_is_wr));
            check("burst_len", 32'(burst_len), 32'(m_len));
            check("wr_count", 32'(wr_count), 32'(m_wr_cnt));
            check("rd_count", 32'(rd_count), 32'(m_rd_cnt));
            check("burst_state", 32'(burst_state),
                  open ? ((open_type == 1) ? 32'(WR_BURST) : 32'(RD_BURST)) : 32'(IDLE));
        end
    end

    // Observed traffic for the directed literal checks
    logic [7:0]  obs_rd_q [$];
    logic [16:0] obs_burst_q [$];
    int          obs_coll = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) obs_rd_q.push_back(rd_data);
            if (burst_done) obs_burst_q.push_back({burst_is_wr, burst_len});
            if (collision) obs_coll++;
        end
    end

    task automatic drive(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        wr_en = w; rd_en = r; address = a; wr_data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        wr_en = 0; rd_en = 0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        wr_en = 0; rd_en = 0;
        #2 rst_n = 0;
        #1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        obs_rd_q.delete();
        obs_burst_q.delete();
        obs_coll = 0;
    endtask

    task automatic check_bursts(input string name, input logic [16:0] exp0, input logic [16:0] exp1, input int n);
        check({name, " count"}, 32'(obs_burst_q.size()), 32'(n));
        if (n > 0 && obs_burst_q.size() > 0) check({name, " first"}, 32'(obs_burst_q[0]), 32'(exp0));
        if (n > 1 && obs_burst_q.size() > 1) check({name, " second"}, 32'(obs_burst_q[1]), 32'(exp1));
    endtask

    initial begin
        logic [7:0] a;
        a = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check_en = 1;

        // Reset mid-traffic with reads still in flight
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 8'(8'h10 + i), 8'($urandom_range(0, 255)));
        drive(1'b0, 1'b1, 8'h10, 8'h00);
        drive(1'b0, 1'b1, 8'h11, 8'h00);
        wr_en = 0; rd_en = 0;
        #2 rst_n = 0;
        #1;
        check("t1 rd_valid", 32'(rd_valid), 0);
        check("t1 rd_data", 32'(rd_data), 0);
        check("t1 burst_done", 32'(burst_done), 0);
        check("t1 burst_len", 32'(burst_len), 0);
        check("t1 wr_count", 32'(wr_count), 0);
        check("t1 rd_count", 32'(rd_count), 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        obs_rd_q.delete(); obs_burst_q.delete(); obs_coll = 0;
        idle(RL + 3);
        check("t1 no stale valid", 32'(obs_rd_q.size()), 0);
        check_bursts("t1 bursts", '0, '0, 0);

        // Four writes then four reads
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h10 + i), 8'(8'h21 + i));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(8'h10 + i), 8'h00);
        idle(RL + 2);
        check("t2 rd n", 32'(obs_rd_q.size()), 4);
        for (int i = 0; i < 4 && i < obs_rd_q.size(); i++) check("t2 rd data", 32'(obs_rd_q[i]), 32'(8'h21 + i));
        check_bursts("t2 bursts", 17'h10004, 17'h00004, 2);
        check("t2 wr_count", 32'(wr_count), 4);
        check("t2 rd_count", 32'(rd_count), 4);

        // Address wrap stays one burst
        do_reset();
        drive(1'b1, 1'b0, 8'hFE, 8'h01);
        drive(1'b1, 1'b0, 8'hFF, 8'h02);
        drive(1'b1, 1'b0, 8'h00, 8'h03);
        idle(2);
        check_bursts("t3 wrap", 17'h10003, '0, 1);

        // Collision
        do_reset();
        drive(1'b1, 1'b1, 8'h05, 8'hAA);
        idle(1);
        check("t4 collision pulses", 32'(obs_coll), 1);
        check("t4 rd_count", 32'(rd_count), 0);
        check("t4 wr_count", 32'(wr_count), 1);
        drive(1'b0, 1'b1, 8'h05, 8'h00);
        idle(RL + 1);
        check("t4 rd n", 32'(obs_rd_q.size()), 1);
        if (obs_rd_q.size() > 0) check("t4 rd data", 32'(obs_rd_q[0]), 32'h0AA);
        check("t4 rd_count after", 32'(rd_count), 1);

        // Read then write the same address
        do_reset();
        drive(1'b1, 1'b0, 8'h20, 8'h11);
        idle(1);
        drive(1'b0, 1'b1, 8'h20, 8'h00);
        drive(1'b1, 1'b0, 8'h20, 8'h99);
        drive(1'b0, 1'b1, 8'h20, 8'h00);
        idle(RL + 1);
        check("t5 rd n", 32'(obs_rd_q.size()), 2);
        if (obs_rd_q.size() > 0) check("t5 old data", 32'(obs_rd_q[0]), 32'h011);
        if (obs_rd_q.size() > 1) check("t5 new data", 32'(obs_rd_q[1]), 32'h099);

        // Non-sequential write splits the burst
        do_reset();
        drive(1'b1, 1'b0, 8'h30, 8'h01);
        drive(1'b1, 1'b0, 8'h31, 8'h02);
        drive(1'b1, 1'b0, 8'h40, 8'h03);
        idle(2);
        check_bursts("t6 split", 17'h10002, 17'h10001, 2);

        // Fill memory, then random traffic against the model
        do_reset();
        for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, 8'(i), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) != 0) ? 8'(a + 8'd1) : 8'($urandom_range(0, 255));
            if (sel < 4)       drive(1'b1, 1'b0, a, 8'($urandom_range(0, 255)));
            else if (sel < 8)  drive(1'b0, 1'b1, a, 8'($urandom_range(0, 255)));
            else if (sel == 8) idle(1);
            else               drive(1'b1, 1'b1, a, 8'($urandom_range(0, 255)));
        end
        idle(RL + 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
